// File: rtl/scan_pkg.sv
// Shared types and default sizes for the scan chain controller.
//   scan_state_e    : controller sequence states
//   DEF_NCHAIN      : default number of parallel chains
//   DEF_CHAIN_LEN   : default bits per chain
package scan_pkg;

  localparam int DEF_NCHAIN    = 2;
  localparam int DEF_CHAIN_LEN = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    DONE    = 3'd4
  } scan_state_e;

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Request/completion handshake between the tester side and the controller.
//   start     : request, one cycle wide
//   cap_en    : capture core values before shifting (sampled with start)
//   upd_en    : load the update register after shifting (sampled with start)
//   shift_len : shift count; 0 or more than the chain length means full length
//   busy      : sequence in progress
//   done      : one-cycle completion pulse
//
// Handshake: start is accepted only on an edge where the controller is idle
// (busy low, done low) and ScanMode is high; busy rises on that same edge.
// A start seen at any other time is dropped, never queued. The sequence ends
// with exactly one cycle of done with busy low, unless aborted or reset, in
// which case busy drops and no done is produced.
interface scan_chain_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             start;
  logic             cap_en;
  logic             upd_en;
  logic [CNT_W-1:0] shift_len;
  logic             busy;
  logic             done;

  modport master (output start, cap_en, upd_en, shift_len, input busy, done);
  modport slave  (input start, cap_en, upd_en, shift_len, output busy, done);
endinterface

// File: rtl/scan_chain_seg.sv
// One shift segment of LEN bits. Capture load takes priority over shift.
//   clk, rst_n : clock, asynchronous active-low clear
//   cap_en     : load cap_data in parallel
//   shift_en   : shift left one place, sin entering bit 0
//   sout       : serial output, the segment MSB
//   q          : parallel contents
module scan_chain_seg #(
  parameter int LEN = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cap_en,
  input  logic           shift_en,
  input  logic [LEN-1:0] cap_data,
  input  logic           sin,
  output logic           sout,
  output logic [LEN-1:0] q
);
  logic [LEN-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (cap_en) begin
      sr_q <= cap_data;
    end else if (shift_en) begin
      sr_q <= {sr_q[LEN-2:0], sin};
    end
  end

  assign q    = sr_q;
  assign sout = sr_q[LEN-1];
endmodule

// File: rtl/scan_chain_ctrl.sv
// Multi-chain scan controller: capture -> shift -> update under a
// start/busy/done handshake, driving an update register into the core.
//   ScanClk, ScanClr_n : clock, asynchronous active-low clear
//   ScanMode           : test-mode enable; low aborts to IDLE
//   ScanBypass         : (SCAN_BYPASS_EN only) one-flop bypass per chain
//   hs                 : start/cap_en/upd_en/shift_len in, busy/done out
//   ScanIn / ScanOut   : serial data per chain
//   core_cap           : parallel capture data, chain c at [c*CHAIN_LEN +: CHAIN_LEN]
//   upd_q              : update register, same bit mapping
//   dbg_state          : current sequencer state
// Optional feature macro: SCAN_BYPASS_EN.
module scan_chain_ctrl import scan_pkg::*; #(
  parameter int NCHAIN    = DEF_NCHAIN,
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                        ScanClk,
  input  logic                        ScanClr_n,
  input  logic                        ScanMode,
`ifdef SCAN_BYPASS_EN
  input  logic                        ScanBypass,
`endif
  scan_chain_ctrl_if.slave            hs,
  input  logic [NCHAIN-1:0]           ScanIn,
  input  logic [NCHAIN*CHAIN_LEN-1:0] core_cap,
  output logic [NCHAIN-1:0]           ScanOut,
  output logic [NCHAIN*CHAIN_LEN-1:0] upd_q,
  output scan_state_e                 dbg_state
);
  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, eff_len;
  logic                    updf_q, updf_d;
  logic                    do_cap, do_shift, do_upd;
  logic                    byp_mode;
  logic [NCHAIN-1:0]       seg_out;
  logic [NCHAIN*CHAIN_LEN-1:0] sr;

  // Out-of-range requests fall back to a full-length shift.
  assign eff_len = (hs.shift_len == '0 || hs.shift_len > CNT_W'(CHAIN_LEN))
                   ? CNT_W'(CHAIN_LEN) : hs.shift_len;

`ifdef SCAN_BYPASS_EN
  logic              byp_q, byp_d;
  logic [NCHAIN-1:0] byp_r;
  assign byp_mode = byp_q;
`else
  assign byp_mode = 1'b0;
`endif

  always_ff @(posedge ScanClk or negedge ScanClr_n) begin
    if (!ScanClr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      updf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      updf_q  <= updf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    updf_d   = updf_q;
    do_cap   = 1'b0;
    do_shift = 1'b0;
    do_upd   = 1'b0;
`ifdef SCAN_BYPASS_EN
    byp_d    = byp_q;
`endif
    case (state_q)
      IDLE: begin
        if (hs.start && ScanMode) begin
          updf_d  = hs.upd_en;
          cnt_d   = eff_len;
          state_d = hs.cap_en ? CAPTURE : SHIFT;
`ifdef SCAN_BYPASS_EN
          byp_d = ScanBypass;
          // Bypass: a single shift through the one-flop path, no capture/update.
          if (ScanBypass) begin
            updf_d  = 1'b0;
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end
`endif
        end
      end
      CAPTURE: begin
        do_cap  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        do_shift = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = updf_q ? UPDATE : DONE;
        end
      end
      UPDATE: begin
        do_upd  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Leaving test mode cancels whatever step was due; sr keeps partial data.
    if (state_q != IDLE && !ScanMode) begin
      state_d  = IDLE;
      do_cap   = 1'b0;
      do_shift = 1'b0;
      do_upd   = 1'b0;
    end
  end

  for (genvar c = 0; c < NCHAIN; c++) begin : g_chain
    scan_chain_seg #(.LEN(CHAIN_LEN)) u_seg (
      .clk      (ScanClk),
      .rst_n    (ScanClr_n),
      .cap_en   (do_cap),
      .shift_en (do_shift && !byp_mode),
      .cap_data (core_cap[c*CHAIN_LEN +: CHAIN_LEN]),
      .sin      (ScanIn[c]),
      .sout     (seg_out[c]),
      .q        (sr[c*CHAIN_LEN +: CHAIN_LEN])
    );
  end

  always_ff @(posedge ScanClk or negedge ScanClr_n) begin
    if (!ScanClr_n) begin
      upd_q <= '0;
    end else if (do_upd) begin
      upd_q <= sr;
    end
  end

`ifdef SCAN_BYPASS_EN
  always_ff @(posedge ScanClk or negedge ScanClr_n) begin
    if (!ScanClr_n) begin
      byp_q <= 1'b0;
      byp_r <= '0;
    end else begin
      byp_q <= byp_d;
      if (do_shift && byp_q) begin
        byp_r <= ScanIn;
      end
    end
  end
  assign ScanOut = byp_mode ? byp_r : seg_out;
`else
  assign ScanOut = seg_out;
`endif

  assign hs.busy   = (state_q == CAPTURE) || (state_q == SHIFT) || (state_q == UPDATE);
  assign hs.done   = (state_q == DONE);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
module tb_scan_chain_ctrl;
  import scan_pkg::*;

  localparam int NCHAIN    = 2;
  localparam int CHAIN_LEN = 4;
  localparam int CNT_W     = 3;
  localparam int W         = NCHAIN * CHAIN_LEN;

  logic                ScanClk = 1'b0;
  logic                ScanClr_n;
  logic                ScanMode;
  logic [NCHAIN-1:0]   ScanIn;
  logic [NCHAIN-1:0]   ScanOut;
  logic [W-1:0]        core_cap;
  logic [W-1:0]        upd_q;
  scan_state_e         dbg_state;
`ifdef SCAN_BYPASS_EN
  logic                ScanBypass;
`endif

  scan_chain_ctrl_if #(.CNT_W(CNT_W)) hs();

  scan_chain_ctrl #(.NCHAIN(NCHAIN), .CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) dut (
    .ScanClk    (ScanClk),
    .ScanClr_n  (ScanClr_n),
    .ScanMode   (ScanMode),
`ifdef SCAN_BYPASS_EN
    .ScanBypass (ScanBypass),
`endif
    .hs         (hs),
    .ScanIn     (ScanIn),
    .core_cap   (core_cap),
    .ScanOut    (ScanOut),
    .upd_q      (upd_q),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ScanClk = ~ScanClk;

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge ScanClk);
    #1;
  endtask

  // ---------------- vector table ----------------
  // sin/exp_out pack one 2-bit {chain1,chain0} value per shift step k at [2k +: 2].
  typedef struct {
    logic       cap_en;
    logic       upd_en;
    logic [2:0] len;
    logic [7:0] core;
    logic [7:0] sin;
    logic [7:0] exp_upd;
    logic [7:0] exp_out;
    bit         chk_out;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic c, input logic u, input logic [2:0] l,
                              input logic [7:0] core, input logic [7:0] sin,
                              input logic [7:0] eu, input logic [7:0] eo,
                              input bit co, input int lat);
    vec_t v;
    v.cap_en = c; v.upd_en = u; v.len = l; v.core = core; v.sin = sin;
    v.exp_upd = eu; v.exp_out = eo; v.chk_out = co; v.exp_lat = lat;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int l;
    int k;
    logic [7:0] obs;
    l = (v.len == 0 || v.len > 3'(CHAIN_LEN)) ? CHAIN_LEN : int'(v.len);
    hs.cap_en    = v.cap_en;
    hs.upd_en    = v.upd_en;
    hs.shift_len = v.len;
    core_cap     = v.core;
    hs.start     = 1'b1;
    tick();
    hs.start = 1'b0;
    check($sformatf("v%0d_busy_c1", idx), hs.busy, 1'b1);
    lat = 0;
    obs = '0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      k = n - int'(v.cap_en) - 1;
      if (k >= 0 && k < l) begin
        ScanIn = v.sin[2*k +: 2];
        obs[2*k +: 2] = ScanOut;
      end else begin
        ScanIn = '0;
      end
      if (hs.done) begin
        lat = n;
        check($sformatf("v%0d_busy_in_done", idx), hs.busy, 1'b0);
      end else begin
        tick();
      end
    end
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_upd_q", idx), upd_q, exp_q.pop_front());
    if (v.chk_out) check($sformatf("v%0d_scanout_seq", idx), obs, v.exp_out);
    tick();
    check($sformatf("v%0d_done_pulse_width", idx), hs.done, 1'b0);
    ScanIn = '0;
  endtask

  // ---------------- test ----------------
  initial begin
    int seen;
    int extra;

    // upd_q = {chain1, chain0}; ScanIn steps as {ScanIn[1], ScanIn[0]}.
    vecs[0] = mk(1'b0, 1'b1, 3'd4, 8'h00, 8'hD1, 8'h1B, 8'h00, 1'b0, 6); // 1011 / 0001
    vecs[1] = mk(1'b1, 1'b0, 3'd4, 8'hA5, 8'h00, 8'h1B, 8'h66, 1'b1, 6); // out 0101 / 1010
    vecs[2] = mk(1'b1, 1'b1, 3'd2, 8'hA5, 8'h0F, 8'hB7, 8'h00, 1'b0, 5); // 0101->0111, 1010->1011
    vecs[3] = mk(1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 8'hF6, 1'b1, 6); // len 0 = full
    vecs[4] = mk(1'b1, 1'b1, 3'd7, 8'h3C, 8'hC6, 8'h95, 8'hA5, 1'b1, 7); // len 7 = full
    vecs[5] = mk(1'b0, 1'b1, 3'd1, 8'h00, 8'h01, 8'h2B, 8'h02, 1'b1, 3); // single shift

    ScanClr_n    = 1'b0;
    ScanMode     = 1'b1;
    ScanIn       = '0;
    core_cap     = '0;
    hs.start     = 1'b0;
    hs.cap_en    = 1'b0;
    hs.upd_en    = 1'b0;
    hs.shift_len = '0;
`ifdef SCAN_BYPASS_EN
    ScanBypass   = 1'b0;
`endif
    #2;
    check("rst_upd_q", upd_q, 8'h00);
    check("rst_scanout", ScanOut, 2'b00);
    check("rst_busy", hs.busy, 1'b0);
    check("rst_done", hs.done, 1'b0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    #10;
    ScanClr_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].exp_upd);
      run_vec(vecs[i], i);
    end

    // Abort during the second shift cycle.
    hs.cap_en = 1'b0; hs.upd_en = 1'b1; hs.shift_len = 3'd4;
    hs.start = 1'b1;
    tick();
    hs.start = 1'b0;
    tick();
    ScanMode = 1'b0;
    tick();
    check("abort_busy", hs.busy, 1'b0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    ScanMode = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (hs.done) extra++;
      tick();
    end
    check("abort_no_done", extra, 0);
    check("abort_upd_q_held", upd_q, 8'h2B);

    // start while ScanMode is low is ignored.
    ScanMode = 1'b0;
    hs.start = 1'b1;
    tick();
    hs.start = 1'b0;
    check("start_no_mode_busy", hs.busy, 1'b0);
    ScanMode = 1'b1;
    tick();

    // start while busy and start during DONE are both dropped.
    hs.cap_en = 1'b0; hs.upd_en = 1'b0; hs.shift_len = 3'd4;
    hs.start = 1'b1;
    tick();
    hs.start = 1'b0;
    tick();
    hs.start = 1'b1;
    tick();
    hs.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      if (hs.done) seen = 1;
      else tick();
    end
    check("busy_start_done_seen", seen, 1);
    hs.start = 1'b1;
    tick();
    hs.start = 1'b0;
    check("start_in_done_ignored", hs.busy, 1'b0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (hs.done) extra++;
      tick();
    end
    check("no_second_done", extra, 0);
    check("no_update_upd_q", upd_q, 8'h2B);

`ifdef SCAN_BYPASS_EN
    ScanBypass = 1'b1;
    hs.cap_en = 1'b1; hs.upd_en = 1'b1; hs.shift_len = 3'd4;
    core_cap = 8'hFF;
    hs.start = 1'b1;
    tick();
    hs.start = 1'b0;
    ScanBypass = 1'b0;
    ScanIn = 2'b10;
    check("byp_busy", hs.busy, 1'b1);
    tick();
    ScanIn = 2'b00;
    check("byp_scanout", ScanOut, 2'b10);
    check("byp_done_at_2", hs.done, 1'b1);
    check("byp_upd_q", upd_q, 8'h2B);
    tick();
`endif

    // Asynchronous reset in the middle of a sequence, between clock edges.
    hs.cap_en = 1'b1; hs.upd_en = 1'b1; hs.shift_len = 3'd4;
    core_cap = 8'hFF;
    hs.start = 1'b1;
    tick();
    hs.start = 1'b0;
    tick();
    #3;
    ScanClr_n = 1'b0;
    #1;
    check("midrst_upd_q", upd_q, 8'h00);
    check("midrst_scanout", ScanOut, 2'b00);
    check("midrst_busy", hs.busy, 1'b0);
    check("midrst_done", hs.done, 1'b0);
    #2;
    ScanClr_n = 1'b1;
    tick();
    check("post_rst_done", hs.done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
